// File: rtl/simon_button_ctrl.sv
// simon_button_ctrl
//   Input controller between the four raw player pushbuttons and the Simon
//   game core. Synchronizes and debounces the button vector, arbitrates
//   simultaneous/illegal presses and emits one single-cycle press pulse with
//   a 2-bit button number per accepted press.
//
// Parameters:
//   DEBOUNCE_TICKS : cycles btn_s must differ from btn_db before adoption (1..15)
//   HOLD_MAX       : cycles an accepted button may be held before stuck (1..255)
//
// Ports:
//   clk            : game clock
//   reset          : synchronous, active-high reset
//   btn[3:0]       : raw asynchronous buttons, bit i = button number i
//   simon_turn     : core is playing its sequence; presses ignored
//   game_over      : game ended; presses ignored, btn_echo forced to 0
//   player_num     : number of the last accepted button (held)
//   player_pressed : one-cycle pulse per accepted press
//   btn_echo       : debounced button vector for LED feedback
//   multi_err      : one-cycle pulse when several buttons become active from IDLE
//   stuck          : accepted button held HOLD_MAX cycles; clears on full release
//   press_count    : accepted presses since reset, saturating at 255
//
// Build option:
//   SIMON_PRESS_ON_RELEASE_EN : defer player_pressed and the press_count
//   increment to the release of the accepted button; stuck presses emit nothing.

module simon_button_ctrl #(
    parameter int unsigned DEBOUNCE_TICKS = 3,
    parameter int unsigned HOLD_MAX       = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       simon_turn,
    input  logic       game_over,
    output logic [1:0] player_num,
    output logic       player_pressed,
    output logic [3:0] btn_echo,
    output logic       multi_err,
    output logic       stuck,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {IDLE, HELD, WAIT_REL} state_t;

    localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE_TICKS - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [3:0] sync1;
    logic [3:0] btn_s;
    logic [3:0] btn_db;
    logic [3:0] db_cnt;
    logic [7:0] hold_cnt;

    state_t     state, state_nxt;
    logic [1:0] num_nxt;
    logic       pressed_nxt;
    logic       multi_nxt;
    logic       stuck_nxt;
    logic [7:0] count_nxt;
    logic [7:0] hold_nxt;

    logic [2:0] n_set;
    logic [1:0] btn_idx;
    logic [7:0] count_sat;

    // Two-flop synchronizer, then whole-vector debounce.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            btn_s  <= '0;
            btn_db <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= btn;
            btn_s <= sync1;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        n_set = {2'b00, btn_db[0]} + {2'b00, btn_db[1]}
              + {2'b00, btn_db[2]} + {2'b00, btn_db[3]};
    end

    // Only consulted when exactly one bit is set.
    always_comb begin
        btn_idx = 2'd0;
        case (1'b1)
            btn_db[1]: btn_idx = 2'd1;
            btn_db[2]: btn_idx = 2'd2;
            btn_db[3]: btn_idx = 2'd3;
            default:   btn_idx = 2'd0;
        endcase
    end

    assign count_sat = (press_count == 8'hFF) ? press_count : press_count + 8'd1;

    always_comb begin
        state_nxt   = state;
        num_nxt     = player_num;
        pressed_nxt = 1'b0;
        multi_nxt   = 1'b0;
        stuck_nxt   = stuck;
        count_nxt   = press_count;
        hold_nxt    = hold_cnt;
        case (state)
            IDLE: begin
                if (btn_db != '0) begin
                    if (n_set > 3'd1) begin
                        multi_nxt = 1'b1;
                        state_nxt = WAIT_REL;
                    end else if (!simon_turn && !game_over) begin
                        num_nxt   = btn_idx;
                        hold_nxt  = '0;
                        state_nxt = HELD;
`ifndef SIMON_PRESS_ON_RELEASE_EN
                        pressed_nxt = 1'b1;
                        count_nxt   = count_sat;
`endif
                    end else begin
                        state_nxt = WAIT_REL;
                    end
                end
            end
            HELD: begin
                if (btn_db == '0) begin
                    state_nxt = IDLE;
`ifdef SIMON_PRESS_ON_RELEASE_EN
                    pressed_nxt = 1'b1;
                    count_nxt   = count_sat;
`endif
                end else if (hold_cnt == HOLD_LAST) begin
                    stuck_nxt = 1'b1;
                    state_nxt = WAIT_REL;
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            WAIT_REL: begin
                if (btn_db == '0) begin
                    stuck_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            player_num     <= '0;
            player_pressed <= 1'b0;
            multi_err      <= 1'b0;
            stuck          <= 1'b0;
            press_count    <= '0;
            hold_cnt       <= '0;
        end else begin
            state          <= state_nxt;
            player_num     <= num_nxt;
            player_pressed <= pressed_nxt;
            multi_err      <= multi_nxt;
            stuck          <= stuck_nxt;
            press_count    <= count_nxt;
            hold_cnt       <= hold_nxt;
        end
    end

    assign btn_echo = btn_db & ~{4{game_over}};

endmodule

// File: doc/simon_button_ctrl.md
Name: simon_button_ctrl

Overview:
- Input controller between the four raw player pushbuttons and the Simon game core.
- Synchronizes and debounces the buttons, then arbitrates simultaneous or illegal presses.
- Emits exactly one single-cycle press pulse with a 2-bit button number per accepted press.
- Gates input by the core's turn and game-over status, and flags stuck buttons and multi-button presses.

Parameters:
- DEBOUNCE_TICKS, default 3: consecutive clk cycles the synchronized vector must differ from the debounced vector before it is adopted. Legal range 1..15.
- HOLD_MAX, default 120: clk cycles a single accepted button may stay held before it is declared stuck. Legal range 1..255.

Ports:
- clk  in  1  game clock, 60 Hz tick domain.
- reset  in  1  synchronous, active-high reset.
- btn  in  4  raw asynchronous buttons, one-hot intent; bit i means button number i.
- simon_turn  in  1  high while the core is playing its sequence; presses are ignored while high.
- game_over  in  1  high when the core has ended the game; presses are ignored while high.
- player_num  out  2  number of the last accepted button; held until the next acceptance.
- player_pressed  out  1  one-cycle pulse per accepted press.
- btn_echo  out  4  debounced button vector for LED feedback; forced to 0 while game_over.
- multi_err  out  1  one-cycle pulse when more than one button becomes active from IDLE.
- stuck  out  1  level; accepted button held HOLD_MAX cycles; clears on full release.
- press_count  out  8  accepted presses since reset; saturates at 255.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values: all outputs 0. Sync flops, btn_db, db_cnt and hold_cnt are 0. FSM goes to IDLE. Reset takes priority mid-operation; a button still held after reset deasserts is treated as a new press once debounced.
- Sync: btn passes through a 2-flop synchronizer to give btn_s.
- Debounce, whole vector:
  - If btn_s == btn_db, db_cnt is set to 0.
  - Else if db_cnt == DEBOUNCE_TICKS-1, btn_db takes btn_s and db_cnt is set to 0.
  - Else db_cnt increments.
- Latency: a raw change held stable produces player_pressed high on the (DEBOUNCE_TICKS+3)th rising edge after the change is first sampled. With the defaults this is 6 cycles.
- FSM states: IDLE, HELD, WAIT_REL.
- IDLE:
  - btn_db == 0: stay in IDLE.
  - popcount(btn_db) > 1: pulse multi_err, go to WAIT_REL.
  - Exactly one bit set, simon_turn == 0 and game_over == 0: player_num takes the index, pulse player_pressed, press_count increments (saturating), hold_cnt is set to 0, go to HELD.
  - Exactly one bit set but the press is not allowed: no pulse, go to WAIT_REL.
- HELD:
  - btn_db == 0: go to IDLE.
  - Otherwise hold_cnt increments. When hold_cnt == HOLD_MAX-1, stuck is set to 1 and the FSM goes to WAIT_REL.
  - Extra buttons added while in HELD produce no pulse and no multi_err.
  - simon_turn or game_over rising while in HELD has no effect on the press already taken.
- WAIT_REL: btn_db == 0 clears stuck and goes to IDLE. No pulses are generated in this state.
- Rearm: a new press is accepted only after btn_db has returned to 0.
- Pulse limits: player_pressed never stays high two consecutive cycles. multi_err and player_pressed are mutually exclusive.
- btn_echo is btn_db ANDed with the inverse of game_over.

Optional Feature:
- Macro SIMON_PRESS_ON_RELEASE_EN.
- When defined:
  - The acceptance decision and player_num latch still happen on the IDLE-to-HELD transition.
  - player_pressed and the press_count increment are deferred to the HELD-to-IDLE transition, i.e. on release.
  - A press that ends in stuck emits no pulse.
- When undefined: the pulse is issued on press, as described in Behaviour.

Test Plan:
1. Reset, simon_turn=0, game_over=0, btn=4'b0100 held 10 cycles -> player_pressed high exactly once, at edge 6 after the change; player_num=2; press_count=1; btn_echo=4'b0100.
2. btn toggles 4'b0001/4'b0000 every cycle for 8 cycles, then 0 -> no player_pressed, btn_echo stays 0, press_count=0.
3. btn=4'b1010 applied from idle -> multi_err pulses once, no player_pressed. Then release and press 4'b1000 -> player_num=3, one pulse.
4. simon_turn=1 with btn=4'b0010 held, simon_turn drops to 0 while the button is still held -> no pulse. Release and press again -> one pulse, player_num=1.
5. btn=4'b0001 held 130 cycles (HOLD_MAX=120) -> one pulse, stuck=1 on cycle 120 after acceptance. On release, stuck=0 once btn_db=0.
6. 256 valid presses -> press_count=255 after press 255 and stays 255. Reset asserted mid-HELD -> all outputs 0 on the next edge.
